// File: rtl/src_b_if.sv
// -----------------------------------------------------------------------------
// src_b_if
//   Interface that bundles the request, forwarding and result signals of the
//   ALU operand-B stage.
//
//   Modports:
//     master : upstream/ALU side. Drives the request, forwarding, flush and
//              out_ready signals, and observes in_ready, alu_src_b and out_valid.
//     slave  : the operand-B stage itself.
//
//   Signals:
//     in_valid / in_ready    upstream request handshake
//     rs2_addr, rs2_data     rs2 index and regfile read data
//     imm                    decoded immediate
//     select                 0=RS2, 1=IMM, 2=const 4, 3=imm<<12, others=0
//     fwd_valid/ready/addr/data
//                            NUM_FWD forwarding channels, channel k packed
//                            at [5k+4:5k] and [XLEN*k +: XLEN]
//     flush                  kill held and incoming operands
//     alu_src_b / out_valid / out_ready
//                            registered operand-B handshake towards the ALU
// -----------------------------------------------------------------------------
interface src_b_if #(
  parameter int XLEN      = 32,
  parameter int NUM_FWD   = 2,
  parameter int SEL_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4:0]              rs2_addr;
  logic [XLEN-1:0]         rs2_data;
  logic [XLEN-1:0]         imm;
  logic [SEL_WIDTH-1:0]    select;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_ready;
  logic [5*NUM_FWD-1:0]    fwd_addr;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic                    flush;
  logic [XLEN-1:0]         alu_src_b;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_valid, rs2_addr, rs2_data, imm, select,
           fwd_valid, fwd_ready, fwd_addr, fwd_data, flush, out_ready,
    input  in_ready, alu_src_b, out_valid
  );

  modport slave (
    input  in_valid, rs2_addr, rs2_data, imm, select,
           fwd_valid, fwd_ready, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, alu_src_b, out_valid
  );
endinterface

// File: rtl/src_b_stage.sv
// -----------------------------------------------------------------------------
// src_b_stage
//   Registered ALU operand-B stage. Selects operand B from rs2, the immediate
//   or a constant, resolves rs2 read-after-write hazards by forwarding from
//   NUM_FWD later pipeline stages (channel 0 youngest, highest priority),
//   stalls on a pending youngest writer, and hands the result to the ALU
//   through a valid/ready pipeline register with full throughput.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   src_b_if.slave (request, forwarding, flush and result handshake)
//
//   Configuration macro:
//     SRC_B_FWD_EN  defined   -> forwarding and load-use stall present
//                   undefined -> rs2 always from the regfile, never stalls,
//                                fwd_* inputs ignored (decoder interlocks)
// -----------------------------------------------------------------------------
module src_b_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_FWD   = 2,
  parameter int SEL_WIDTH = 3
) (
  input  logic    clk,
  input  logic    rst,
  src_b_if.slave  bus
);

  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic [XLEN-1:0] sel_val;
  logic            capture;
  logic [XLEN-1:0] alu_src_b_q, alu_src_b_d;
  logic            out_valid_q, out_valid_d;

`ifdef SRC_B_FWD_EN
  logic            hit;
  logic            hit_ready;
  logic [XLEN-1:0] hit_data;

  // Priority search: the first (youngest) matching channel wins, and an
  // older channel is never allowed to bypass it, even if the youngest is
  // still pending.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic, so
    // no path leaves it unassigned and no latch is inferred.
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!hit && bus.fwd_valid[k] && (bus.rs2_addr != 5'd0) &&
          (bus.fwd_addr[5*k +: 5] == bus.rs2_addr)) begin
        hit       = 1'b1;
        hit_ready = bus.fwd_ready[k];
        hit_data  = bus.fwd_data[XLEN*k +: XLEN];
      end
    end
  end

  assign rs2_val = hit ? hit_data : bus.rs2_data;
  // Only an RS2 request that is actually being offered can stall.
  assign stall   = bus.in_valid && (bus.select == SEL_WIDTH'(0)) &&
                   hit && !hit_ready;
`else
  // Forwarding inputs are intentionally unused in this build.
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_valid, bus.fwd_ready, bus.fwd_addr,
                        bus.fwd_data};
  assign rs2_val    = bus.rs2_data;
  assign stall      = 1'b0;
`endif

  // Operand-B source mux; unlisted codes give zero.
  always_comb begin
    sel_val = '0;
    case (bus.select)
      SEL_WIDTH'(0): sel_val = rs2_val;
      SEL_WIDTH'(1): sel_val = bus.imm;
      SEL_WIDTH'(2): sel_val = XLEN'(4);
      SEL_WIDTH'(3): sel_val = bus.imm << 12;
      default:       sel_val = '0;
    endcase
  end

  // Accept when not stalled and the output slot is empty or draining now.
  assign bus.in_ready = !stall && (!out_valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  // Flush beats capture and drain; capture beats drain so that a
  // simultaneous drain+capture keeps out_valid high (no bubble).
  always_comb begin
    alu_src_b_d = alu_src_b_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      alu_src_b_d = sel_val;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_src_b_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value, independent of statement order.
      alu_src_b_q <= alu_src_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.alu_src_b = alu_src_b_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_src_b_stage.sv
// -----------------------------------------------------------------------------
// tb_src_b_stage
//   Self-checking bench for src_b_stage: directed steps followed by a
//   randomized phase, all compared against a behavioural operand model.
//   Honours SRC_B_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_src_b_stage;
  localparam int XLEN      = 32;
  localparam int NUM_FWD   = 2;
  localparam int SEL_WIDTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Behavioural view of the output register.
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_data  = '0;
  logic            last_cap;

  src_b_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .SEL_WIDTH(SEL_WIDTH)) bus ();

  src_b_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Operand the rules say should be produced for the current inputs, and
  // whether the request must wait for a pending youngest writer.
  function automatic logic [XLEN-1:0] ref_operand(output logic st);
    logic [XLEN-1:0] r;
    r  = bus.rs2_data;
    st = 1'b0;
`ifdef SRC_B_FWD_EN
    if (bus.select == 0 && bus.rs2_addr != 0) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        if (bus.fwd_valid[k] && bus.fwd_addr[5*k +: 5] == bus.rs2_addr) begin
          if (bus.fwd_ready[k]) r = bus.fwd_data[XLEN*k +: XLEN];
          else                  st = bus.in_valid;
          break;
        end
      end
    end
`endif
    case (int'(bus.select))
      0:       return r;
      1:       return bus.imm;
      2:       return 32'd4;
      3:       return {bus.imm[19:0], 12'h000};
      default: return '0;
    endcase
  endfunction

  // One clock: check in_ready for the driven inputs, advance the model over
  // the edge, then check the registered outputs.
  task automatic cycle(input string tag);
    logic st, rdy, cap;
    logic [XLEN-1:0] val;
    #1;
    val = ref_operand(st);
    rdy = !st && (!m_valid || bus.out_ready);
    cap = bus.in_valid && rdy && !bus.flush;
    check({tag, ".in_ready"}, XLEN'(bus.in_ready), XLEN'(rdy));
    @(posedge clk);
    #1;
    if (bus.flush)                    m_valid = 1'b0;
    else if (cap) begin               m_valid = 1'b1; m_data = val; end
    else if (m_valid && bus.out_ready) m_valid = 1'b0;
    last_cap = cap;
    check({tag, ".out_valid"}, XLEN'(bus.out_valid), XLEN'(m_valid));
    check({tag, ".alu_src_b"}, bus.alu_src_b, m_data);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.rs2_addr  = '0;
    bus.rs2_data  = '0;
    bus.imm       = '0;
    bus.select    = '0;
    bus.fwd_valid = '0;
    bus.fwd_ready = '0;
    bus.fwd_addr  = '0;
    bus.fwd_data  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check("reset.out_valid", XLEN'(bus.out_valid), '0);
    check("reset.alu_src_b", bus.alu_src_b, '0);
    rst = 1'b0;
    #1;
    check("reset.in_ready", XLEN'(bus.in_ready), XLEN'(1));

    // Source select codes.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.select = 3'd1; bus.imm = 32'h0000_0ABC;
    cycle("sel_imm");
    check("sel_imm.const", bus.alu_src_b, 32'h0000_0ABC);
    bus.select = 3'd3;
    cycle("sel_lui");
    check("sel_lui.const", bus.alu_src_b, 32'h00AB_C000);
    bus.select = 3'd2;
    cycle("sel_four");
    check("sel_four.const", bus.alu_src_b, 32'h4);
    bus.select = 3'd7;
    cycle("sel_zero");
    check("sel_zero.const", bus.alu_src_b, 32'h0);

    // Forwarding priority.
    bus.select = 3'd0; bus.rs2_addr = 5'd5; bus.rs2_data = 32'h11;
    bus.fwd_valid = 2'b11; bus.fwd_ready = 2'b11;
    bus.fwd_addr  = {5'd5, 5'd5};
    bus.fwd_data  = {32'h22, 32'h33};
    cycle("fwd_ch0");
`ifdef SRC_B_FWD_EN
    check("fwd_ch0.const", bus.alu_src_b, 32'h33);
`else
    check("fwd_ch0.const", bus.alu_src_b, 32'h11);
`endif
    bus.fwd_valid = 2'b10;
    cycle("fwd_ch1");
`ifdef SRC_B_FWD_EN
    check("fwd_ch1.const", bus.alu_src_b, 32'h22);
`else
    check("fwd_ch1.const", bus.alu_src_b, 32'h11);
`endif
    bus.rs2_addr = 5'd0; bus.fwd_valid = 2'b11; bus.fwd_addr = '0;
    cycle("fwd_x0");
    check("fwd_x0.const", bus.alu_src_b, 32'h11);

    // Load-use: youngest writer pending for two cycles.
    bus.rs2_addr = 5'd5; bus.fwd_addr = {5'd5, 5'd5};
    bus.fwd_valid = 2'b11; bus.fwd_ready = 2'b10;
    bus.fwd_data  = {32'h22, 32'h44};
    cycle("lduse_1");
    cycle("lduse_2");
`ifdef SRC_B_FWD_EN
    check("lduse.stall_in_ready", XLEN'(bus.in_ready), '0);
`endif
    bus.fwd_ready = 2'b11;
    cycle("lduse_3");
`ifdef SRC_B_FWD_EN
    check("lduse.const", bus.alu_src_b, 32'h44);
`endif
    bus.fwd_valid = '0;

    // Back-pressure, then back-to-back throughput.
    bus.out_ready = 1'b0; bus.select = 3'd1; bus.imm = 32'h99;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      check("bp_hold.in_ready", XLEN'(bus.in_ready), '0);
    end
    bus.out_ready = 1'b1;
    cycle("bp_release");  // held value drains while 0x99 loads
    bus.imm = 32'hA;
    cycle("b2b_a");
    check("b2b_a.const", bus.alu_src_b, 32'hA);
    bus.imm = 32'hB;
    cycle("b2b_b");
    check("b2b_b.const", bus.alu_src_b, 32'hB);
    check("b2b_b.valid", XLEN'(bus.out_valid), XLEN'(1));

    // Flush kills the held and incoming operands.
    bus.imm = 32'h77; bus.flush = 1'b1;
    cycle("flush");
    check("flush.out_valid", XLEN'(bus.out_valid), '0);
    check("flush.hold", bus.alu_src_b, 32'hB);
    bus.flush = 1'b0; bus.imm = 32'h5;
    cycle("post_flush");
    check("post_flush.const", bus.alu_src_b, 32'h5);

    // Randomized traffic; request fields held stable until accepted.
    last_cap = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (last_cap || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.select   = SEL_WIDTH'($urandom_range(0, 7));
        bus.rs2_addr = 5'($urandom_range(0, 3));
        bus.rs2_data = $urandom;
        bus.imm      = $urandom;
      end
      bus.fwd_valid = NUM_FWD'($urandom);
      bus.fwd_ready = NUM_FWD'($urandom);
      bus.fwd_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.fwd_data  = {$urandom, $urandom};
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle("random");
    end

    // Asynchronous reset while an operand is held.
    bus.flush = 1'b0; bus.fwd_valid = '0; bus.in_valid = 1'b1;
    bus.select = 3'd1; bus.imm = 32'h123; bus.out_ready = 1'b0;
    cycle("pre_rst");
    cycle("pre_rst_hold");
    check("pre_rst.valid", XLEN'(bus.out_valid), XLEN'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst.out_valid", XLEN'(bus.out_valid), '0);
    check("async_rst.alu_src_b", bus.alu_src_b, '0);
    m_valid = 1'b0; m_data = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
